// File: rtl/y_mc_control_pkg.sv
// Shared encodings for the multi-cycle RV32-subset control sequencer.
// Covers sequencer states, opcodes, ALU ops, PC/writeback selects and the decode bundle.
// Types and constants only. There is no logic in this file.
package y_mc_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LW,
        CL_SW,
        CL_BR,
        CL_JAL
    } iclass_t;

    typedef struct packed {
        logic [2:0] op;
        logic       alu_src;
        logic [1:0] wb_sel;
        iclass_t    cls;
        logic       bne;      // branch polarity: 0 beq, 1 bne
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/y_mc_control_if.sv
// Control/datapath bundle between the sequencer and the RV32 datapath.
// The master modport is the sequencer. The slave modport is the datapath and memory side.
// Memory waits via mem_ready. Every other signal is a plain level.
interface y_mc_control_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ins;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             MemRead;
    logic             MemWrite;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             RegWrite;
    logic [1:0]       wb_sel;
    logic             ALUSrc;
    logic [2:0]       op;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  ins, zero, mem_ready,
        output mem_req, MemRead, MemWrite, ir_we, pc_we, pc_sel,
               RegWrite, wb_sel, ALUSrc, op, halted, retired
    );

    modport slave (
        output ins, zero, mem_ready,
        input  mem_req, MemRead, MemWrite, ir_we, pc_we, pc_sel,
               RegWrite, wb_sel, ALUSrc, op, halted, retired
    );
endinterface

// File: rtl/y_mc_decode.sv
// Instruction decoder that maps ins to ALU op, ALUSrc, wb_sel, class and an illegal flag.
// Purely combinational with zero latency. The sequencer registers the result in DECODE.
// There is no handshake and no backpressure.
module y_mc_decode
    import y_mc_control_pkg::*;
(
    input  logic [31:0] ins,
    output dec_t        dec
);
    logic [2:0] f3;
    logic       unused_ins;

    assign f3         = ins[14:12];
    assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

    // Opcode/funct3 lookup. Anything not listed is flagged illegal.
    always_comb begin
        dec         = '0;
        dec.op      = ALU_ADD;
        dec.cls     = CL_R;
        dec.wb_sel  = WB_ALU;
        case (ins[6:0])
            OPC_R, OPC_I: begin
                dec.cls     = (ins[6:0] == OPC_R) ? CL_R : CL_I;
                dec.alu_src = (ins[6:0] == OPC_I);
                case (f3)
                    3'b000:  dec.op = (ins[6:0] == OPC_R && ins[30]) ? ALU_SUB : ALU_ADD;
                    3'b111:  dec.op = ALU_AND;
                    3'b110:  dec.op = ALU_OR;
                    3'b010:  dec.op = ALU_SLT;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LW: begin
                dec.cls     = CL_LW;
                dec.alu_src = 1'b1;
                dec.wb_sel  = WB_MEM;
                dec.illegal = (f3 != 3'b010);
            end
            OPC_SW: begin
                dec.cls     = CL_SW;
                dec.alu_src = 1'b1;
                dec.illegal = (f3 != 3'b010);
            end
            OPC_BR: begin
                dec.cls     = CL_BR;
                dec.op      = ALU_SUB;
                dec.bne     = f3[0];
                dec.illegal = (f3[2:1] != 2'b00);
            end
            OPC_JAL: begin
                dec.cls    = CL_JAL;
                dec.wb_sel = WB_PC4;
            end
            default: dec.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/y_mc_control.sv
// Multi-cycle sequencer that steps through FETCH/DECODE/EXEC/MEM/WB and drives the datapath controls.
// Retire latency is 3 to 5 cycles plus one per memory wait cycle.
// FETCH and MEM hold until mem_ready. HALT is sticky until reset.
module y_mc_control
    import y_mc_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    y_mc_control_if.master   bus
);
    state_t           state, next_state;
    dec_t             dec;
    logic [2:0]       op_q;
    logic             alu_src_q;
    logic [1:0]       wb_sel_q;
    iclass_t          cls_q;
    logic             bne_q;
    logic [CNT_W-1:0] retired_q;
    logic             mem_req, mem_read, mem_write, ir_we, pc_we, reg_write, halted;
    logic [1:0]       pc_sel;

    y_mc_decode u_decode (
        .ins (bus.ins),
        .dec (dec)
    );

    // State register. Reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Capture the decoded controls once. ins is stable until retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= ALU_AND;
            alu_src_q <= 1'b0;
            wb_sel_q  <= WB_ALU;
            cls_q     <= CL_R;
            bne_q     <= 1'b0;
        end else if (state == S_DECODE) begin
            op_q      <= dec.op;
            alu_src_q <= dec.alu_src;
            wb_sel_q  <= dec.wb_sel;
            cls_q     <= dec.cls;
            bne_q     <= dec.bne;
        end
    end

    // Every pc_we cycle retires one instruction. The counter wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      retired_q <= '0;
        else if (pc_we) retired_q <= retired_q + CNT_W'(1);
    end

    // Next-state logic and state-driven enables.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        reg_write  = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_we      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: next_state = dec.illegal ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    CL_BR: begin
                        pc_we      = 1'b1;
                        pc_sel     = (bne_q ^ bus.zero) ? PC_BRANCH : PC_PLUS4;
                        next_state = S_FETCH;
                    end
                    CL_LW, CL_SW: next_state = S_MEM;
                    default:      next_state = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_write = (cls_q == CL_SW);
                mem_read  = (cls_q != CL_SW);
                if (bus.mem_ready) begin
                    pc_we      = (cls_q == CL_SW);
                    next_state = (cls_q == CL_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = (cls_q == CL_JAL) ? PC_JAL : PC_PLUS4;
                next_state = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: next_state = S_FETCH;
        endcase
        // The state already reads FETCH during reset. This keeps the fetch request quiet too.
        if (reset) begin
            mem_req  = 1'b0;
            mem_read = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
        end
    end

    assign bus.mem_req  = mem_req;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.ir_we    = ir_we;
    assign bus.pc_we    = pc_we;
    assign bus.pc_sel   = pc_sel;
    assign bus.RegWrite = reg_write;
    assign bus.wb_sel   = wb_sel_q;
    // ALU controls come straight from the decoder in DECODE and are held afterwards.
    assign bus.op       = (state == S_DECODE) ? dec.op      : op_q;
    assign bus.ALUSrc   = (state == S_DECODE) ? dec.alu_src : alu_src_q;
    assign bus.halted   = halted;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_y_mc_control.sv
// Bench for y_mc_control: directed vector table, reset/halt sequences and random instructions.
// Two instances run in lockstep. The second has a 2-bit counter so that wrap-around is exercised.
// mem_ready is driven reactively from mem_req with a programmed number of wait cycles.
module tb_y_mc_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    y_mc_control_if #(.CNT_W(32)) b  ();
    y_mc_control_if #(.CNT_W(2))  b2 ();

    assign b2.ins       = b.ins;
    assign b2.zero      = b.zero;
    assign b2.mem_ready = b.mem_ready;

    y_mc_control #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(b.master));
    y_mc_control #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(b2.master));

    typedef struct {
        bit         ill;
        int         cyc;
        logic [1:0] pcs;
        logic [1:0] wbs;
        bit         rw;
        bit         chk_op;
        logic [2:0] op;
        bit         as;
        int         rd;
        int         wr;
    } exp_t;

    typedef struct {
        string       nm;
        logic [31:0] ins;
        logic        zero;
        int          fw;
        int          mw;
        exp_t        e;
    } vec_t;

    typedef struct {
        bit         ret;
        bit         halt;
        int         cyc;
        logic [1:0] pcs;
        logic [1:0] wbs;
        logic       rw;
        logic [2:0] op;
        logic       as;
        int         rd;
        int         wr;
        int         rwc;
        int         irw;
    } obs_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_retired = 0;
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [31:0] ins, input logic z, input int fw,
                           input int mw, input bit ill, input int cyc, input logic [1:0] pcs,
                           input logic [1:0] wbs, input bit rw, input bit chk_op,
                           input logic [2:0] op, input bit as, input int rd, input int wr);
        vec_t v;
        v.nm = nm; v.ins = ins; v.zero = z; v.fw = fw; v.mw = mw;
        v.e.ill = ill; v.e.cyc = cyc; v.e.pcs = pcs; v.e.wbs = wbs; v.e.rw = rw;
        v.e.chk_op = chk_op; v.e.op = op; v.e.as = as; v.e.rd = rd; v.e.wr = wr;
        tbl.push_back(v);
    endtask

    // Reference model. It derives the expected retire behaviour from the instruction class
    // and the number of memory wait cycles.
    function automatic exp_t model(input logic [31:0] i, input logic z, input int fw, input int mw);
        exp_t e;
        logic [2:0] f3;
        f3 = i[14:12];
        e.ill = 0; e.pcs = 2'b00; e.wbs = 2'b00; e.rw = 0; e.chk_op = 1;
        e.op = 3'b010; e.as = 0; e.rd = fw + 1; e.wr = 0; e.cyc = 0;
        case (i[6:0])
            7'h33, 7'h13: begin
                e.rw  = 1;
                e.as  = (i[6:0] == 7'h13);
                e.cyc = fw + 4;
                if (f3 == 3'b000)      e.op = (i[6:0] == 7'h33 && i[30]) ? 3'b110 : 3'b010;
                else if (f3 == 3'b111) e.op = 3'b000;
                else if (f3 == 3'b110) e.op = 3'b001;
                else if (f3 == 3'b010) e.op = 3'b111;
                else                   e.ill = 1;
            end
            7'h03: begin
                e.ill = (f3 != 3'b010); e.as = 1; e.rw = 1; e.wbs = 2'b01;
                e.cyc = fw + 5 + mw; e.rd = fw + 1 + mw + 1;
            end
            7'h23: begin
                e.ill = (f3 != 3'b010); e.as = 1;
                e.cyc = fw + 4 + mw; e.wr = mw + 1;
            end
            7'h63: begin
                e.ill = (f3 > 3'b001); e.op = 3'b110; e.cyc = fw + 3;
                e.pcs = ((f3 == 3'b000) ? z : !z) ? 2'b01 : 2'b00;
            end
            7'h6F: begin
                e.rw = 1; e.wbs = 2'b10; e.pcs = 2'b10; e.chk_op = 0; e.cyc = fw + 4;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) e.cyc = fw + 3;
        return e;
    endfunction

    // Run one instruction from its first FETCH cycle to retire or halt.
    task automatic run_one(input logic [31:0] i, input logic z, input int fw, input int mw,
                           output obs_t o);
        int fleft, mleft;
        bit fetched;
        o.ret = 0; o.halt = 0; o.cyc = 0; o.pcs = 0; o.wbs = 0; o.rw = 0; o.op = 0; o.as = 0;
        o.rd = 0; o.wr = 0; o.rwc = 0; o.irw = 0;
        fleft = fw; mleft = mw; fetched = 0;
        b.ins = i; b.zero = z;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (b.mem_req) begin
                if (!fetched) begin b.mem_ready = (fleft == 0); if (fleft > 0) fleft--; end
                else          begin b.mem_ready = (mleft == 0); if (mleft > 0) mleft--; end
            end else begin
                b.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            o.cyc++;
            if (b.mem_req && b.MemRead) o.rd++;
            if (b.MemWrite) o.wr++;
            if (b.RegWrite) o.rwc++;
            if (b.ir_we) begin o.irw++; fetched = 1; end
            if (b.pc_we) begin
                o.ret = 1; o.pcs = b.pc_sel; o.wbs = b.wb_sel; o.rw = b.RegWrite;
                o.op = b.op; o.as = b.ALUSrc;
                break;
            end
            if (b.halted) begin o.halt = 1; break; end
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1'b1;
        b.mem_ready = 1'b0;
        #1;
        chk({nm, ".rst_retired"}, b.retired, 32'd0);
        chk({nm, ".rst_retired2"}, 32'(b2.retired), 32'd0);
        chk({nm, ".rst_halted"}, 32'(b.halted), 32'd0);
        chk({nm, ".rst_enables"}, 32'({b.mem_req, b.MemWrite, b.pc_we, b.RegWrite, b.ir_we}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({nm, ".rst_fetch"}, 32'({b.mem_req, b.MemRead, b.MemWrite}), 32'b110);
        exp_retired = 0;
    endtask

    task automatic after_halt(input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            b.mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (b.pc_we || b.RegWrite || b.MemWrite || b.ir_we || b.mem_req || !b.halted) bad++;
        end
        chk({nm, ".halt_quiet"}, 32'(bad), 32'd0);
        chk({nm, ".halt_retired"}, b.retired, exp_retired);
        do_reset({nm, ".after_halt"});
    endtask

    task automatic compare(input string nm, input exp_t e, input obs_t o);
        chk({nm, ".outcome"}, o.ret ? 32'd1 : (o.halt ? 32'd2 : 32'd0), e.ill ? 32'd2 : 32'd1);
        chk({nm, ".cycles"}, o.cyc, e.cyc);
        if (e.ill) begin
            after_halt(nm);
        end else begin
            chk({nm, ".pc_sel"}, 32'(o.pcs), 32'(e.pcs));
            chk({nm, ".RegWrite"}, 32'(o.rw), 32'(e.rw));
            chk({nm, ".rw_cycles"}, o.rwc, e.rw ? 32'd1 : 32'd0);
            if (e.rw) chk({nm, ".wb_sel"}, 32'(o.wbs), 32'(e.wbs));
            if (e.chk_op) begin
                chk({nm, ".op"}, 32'(o.op), 32'(e.op));
                chk({nm, ".ALUSrc"}, 32'(o.as), 32'(e.as));
            end
            chk({nm, ".read_cycles"}, o.rd, e.rd);
            chk({nm, ".write_cycles"}, o.wr, e.wr);
            chk({nm, ".ir_we"}, o.irw, 32'd1);
            @(posedge clk);
            #1;
            exp_retired = exp_retired + 1;
            chk({nm, ".retired"}, b.retired, exp_retired);
            chk({nm, ".retired2"}, 32'(b2.retired), 32'(exp_retired[1:0]));
        end
    endtask

    initial begin
        obs_t o;
        b.ins = 32'h0; b.zero = 1'b0; b.mem_ready = 1'b0;

        //       name      ins           z  fw mw ill cyc pcs    wbs    rw chk op      as rd wr
        add_vec("add",    32'h002081B3, 0, 0, 0, 0,  4, 2'b00, 2'b00, 1, 1, 3'b010, 0, 1, 0);
        add_vec("lw_wait",32'h0000A283, 0, 0, 3, 0,  8, 2'b00, 2'b01, 1, 1, 3'b010, 1, 5, 0);
        add_vec("beq_t",  32'h00208463, 1, 0, 0, 0,  3, 2'b01, 2'b00, 0, 1, 3'b110, 0, 1, 0);
        add_vec("bne_nt", 32'h00209463, 1, 0, 0, 0,  3, 2'b00, 2'b00, 0, 1, 3'b110, 0, 1, 0);
        add_vec("jal",    32'h008000EF, 0, 0, 0, 0,  4, 2'b10, 2'b10, 1, 0, 3'b000, 0, 1, 0);
        add_vec("sw_wait",32'h0050A023, 0, 1, 2, 0,  7, 2'b00, 2'b00, 0, 1, 3'b010, 1, 2, 3);
        add_vec("sub",    32'h402081B3, 0, 0, 0, 0,  4, 2'b00, 2'b00, 1, 1, 3'b110, 0, 1, 0);
        add_vec("andi",   32'h0050F093, 0, 2, 0, 0,  6, 2'b00, 2'b00, 1, 1, 3'b000, 1, 3, 0);
        add_vec("slt",    32'h0020A1B3, 0, 0, 0, 0,  4, 2'b00, 2'b00, 1, 1, 3'b111, 0, 1, 0);
        add_vec("or",     32'h0020E1B3, 0, 0, 0, 0,  4, 2'b00, 2'b00, 1, 1, 3'b001, 0, 1, 0);
        add_vec("beq_nt", 32'h00208463, 0, 0, 0, 0,  3, 2'b00, 2'b00, 0, 1, 3'b110, 0, 1, 0);
        add_vec("bne_t",  32'h00209463, 0, 0, 0, 0,  3, 2'b01, 2'b00, 0, 1, 3'b110, 0, 1, 0);
        add_vec("lw",     32'h0000A283, 0, 0, 0, 0,  5, 2'b00, 2'b01, 1, 1, 3'b010, 1, 2, 0);
        add_vec("sw",     32'h0050A023, 0, 0, 0, 0,  4, 2'b00, 2'b00, 0, 1, 3'b010, 1, 1, 1);
        add_vec("opc7f",  32'h0000007F, 0, 0, 0, 1,  3, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0);
        add_vec("sll",    32'h002091B3, 0, 1, 0, 1,  4, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0);
        add_vec("blt",    32'h0020C463, 0, 0, 0, 1,  3, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0);

        do_reset("init");

        foreach (tbl[n]) begin
            run_one(tbl[n].ins, tbl[n].zero, tbl[n].fw, tbl[n].mw, o);
            compare(tbl[n].nm, tbl[n].e, o);
        end

        // Build up a nonzero count, then reset in the middle of a stalled store.
        for (int k = 0; k < 3; k++) begin
            run_one(32'h002081B3, 1'b0, 0, 0, o);
            compare("pre_sw", model(32'h002081B3, 1'b0, 0, 0), o);
        end
        b.ins = 32'h0050A023;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b.mem_ready = (k == 0);
            #1;
        end
        chk("swrst.in_mem", 32'({b.mem_req, b.MemWrite, b.MemRead}), 32'b110);
        chk("swrst.count_before", 32'(b.retired != 0), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("swrst.drop", 32'({b.mem_req, b.MemWrite, b.pc_we, b.RegWrite}), 32'd0);
        chk("swrst.retired", b.retired, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("swrst.fetch", 32'({b.mem_req, b.MemRead, b.MemWrite}), 32'b110);
        exp_retired = 0;

        // Random instructions compared against the reference model.
        for (int r = 0; r < 40; r++) begin
            logic [31:0] ri;
            logic        rz;
            int          rfw, rmw;
            ri = $urandom;
            case ($urandom_range(0, 7))
                0: ri[6:0] = 7'h33;
                1: ri[6:0] = 7'h13;
                2: begin ri[6:0] = 7'h03; ri[14:12] = 3'b010; end
                3: begin ri[6:0] = 7'h23; ri[14:12] = 3'b010; end
                4: begin ri[6:0] = 7'h63; ri[14:13] = 2'b00; end
                5: ri[6:0] = 7'h6F;
                default: ;
            endcase
            rz  = 1'($urandom_range(0, 1));
            rfw = $urandom_range(0, 2);
            rmw = $urandom_range(0, 3);
            run_one(ri, rz, rfw, rmw, o);
            compare($sformatf("rnd%0d_%08h", r, ri), model(ri, rz, rfw, rmw), o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
